// File: rtl/gshare_predictor.sv
// gshare_predictor: PHT of saturating counters indexed by speculative (lookup) or committed (train) history.
// Define GSHARE_PC_XOR_EN to XOR pc[HIST_W+1:2] into the index (gshare); otherwise the index is history only.
module gshare_predictor #(
  parameter int ADDR_W   = 32,
  parameter int HIST_W   = 8,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              insert_en,
  input  logic              mux,
  input  logic [ADDR_W-1:0] pc1,
  input  logic [ADDR_W-1:0] pc2,
  output logic              predict1,
  output logic              predict2,
  input  logic              modify_en,
  input  logic              clear,
  input  logic              choice,
  input  logic [ADDR_W-1:0] upd_pc
);

  localparam int               PHT_D   = 2 ** HIST_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [CTR_W-1:0]  pht [PHT_D];
  logic [HIST_W-1:0] gh;
  logic [HIST_W-1:0] ghb;
  logic [HIST_W-1:0] lk_idx1;
  logic [HIST_W-1:0] lk_idx2;
  logic [HIST_W-1:0] upd_idx;
  logic [HIST_W-1:0] ghb_next;
  logic [CTR_W-1:0]  upd_ctr;
  logic [CTR_W-1:0]  upd_ctr_next;
  logic              ins_bit;
  logic              unused_pc_bits;

`ifdef GSHARE_PC_XOR_EN
  assign lk_idx1 = gh ^ pc1[HIST_W+1:2];
  assign lk_idx2 = gh ^ pc2[HIST_W+1:2];
  assign upd_idx = ghb ^ upd_pc[HIST_W+1:2];
`else
  assign lk_idx1 = gh;
  assign lk_idx2 = gh;
  assign upd_idx = ghb;
`endif

  // Only a slice of each PC feeds the index (none in pure-global mode).
  assign unused_pc_bits = ^{pc1, pc2, upd_pc};

  assign predict1 = pht[lk_idx1][CTR_W-1];
  assign predict2 = pht[lk_idx2][CTR_W-1];
  assign ins_bit  = mux ? predict2 : predict1;
  assign ghb_next = {ghb[HIST_W-2:0], choice};
  assign upd_ctr  = pht[upd_idx];

  always_comb begin
    upd_ctr_next = upd_ctr;
    if (choice) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + CTR_W'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - CTR_W'(1);
    end
  end

  // A mispredict recovery rebuilds gh from committed history and drops any same-cycle insert.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_D; i++) pht[i] <= CTR_RST;
      gh  <= '0;
      ghb <= '0;
    end else if (rdy) begin
      if (modify_en) begin
        pht[upd_idx] <= upd_ctr_next;
        ghb          <= ghb_next;
      end
      if (modify_en && clear) gh <= ghb_next;
      else if (insert_en)     gh <= {gh[HIST_W-2:0], ins_bit};
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed + random stimulus, expected predictions queued from an arithmetic
// reference model and compared by an independent monitor.
module tb_gshare_predictor;

  localparam int ADDR_W   = 32;
  localparam int HIST_W   = 8;
  localparam int CTR_W    = 2;
  localparam int CTR_INIT = 1;
  localparam int PHT_D    = 1 << HIST_W;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int TAKEN_TH = 1 << (CTR_W - 1);

  typedef struct {
    bit              rst;
    bit              rdy;
    bit              insert_en;
    bit              mux;
    bit              modify_en;
    bit              clear;
    bit              choice;
    logic [ADDR_W-1:0] pc1;
    logic [ADDR_W-1:0] pc2;
    logic [ADDR_W-1:0] upd_pc;
  } stim_t;

  typedef struct {
    bit p1;
    bit p2;
    int cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, rdy, insert_en, mux, modify_en, clear, choice;
  logic [ADDR_W-1:0] pc1, pc2, upd_pc;
  logic              predict1, predict2;

  exp_t  exp_q[$];
  int    pht_m[PHT_D];
  int    gh_m  = 0;
  int    ghb_m = 0;
  stim_t last_s;
  bit    last_p1, last_p2;
  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;

  gshare_predictor #(
    .ADDR_W(ADDR_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .CTR_INIT(CTR_INIT)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .insert_en(insert_en), .mux(mux),
    .pc1(pc1), .pc2(pc2), .predict1(predict1), .predict2(predict2),
    .modify_en(modify_en), .clear(clear), .choice(choice), .upd_pc(upd_pc)
  );

  always #5 clk = ~clk;

  function automatic int idx(int h, logic [ADDR_W-1:0] pc);
`ifdef GSHARE_PC_XOR_EN
    return h ^ int'((pc >> 2) & (PHT_D - 1));
`else
    return h;
`endif
  endfunction

  function automatic bit model_pred(logic [ADDR_W-1:0] pc);
    return pht_m[idx(gh_m, pc)] >= TAKEN_TH;
  endfunction

  // Advance the model by one clock edge for the stimulus that was applied during that cycle.
  function automatic void model_step(stim_t s, bit p1, bit p2);
    int i;
    int g;
    if (s.rst) begin
      foreach (pht_m[k]) pht_m[k] = CTR_INIT;
      gh_m  = 0;
      ghb_m = 0;
      return;
    end
    if (!s.rdy) return;
    g = gh_m;
    if (s.insert_en) g = (gh_m * 2 + int'(s.mux ? p2 : p1)) % PHT_D;
    if (s.modify_en) begin
      i = idx(ghb_m, s.upd_pc);
      if (s.choice) pht_m[i] = (pht_m[i] < CTR_MAX) ? pht_m[i] + 1 : CTR_MAX;
      else          pht_m[i] = (pht_m[i] > 0) ? pht_m[i] - 1 : 0;
      ghb_m = (ghb_m * 2 + int'(s.choice)) % PHT_D;
      if (s.clear) g = ghb_m;
    end
    gh_m = g;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.rdy = 1; s.insert_en = 0; s.mux = 0;
    s.modify_en = 0; s.clear = 0; s.choice = 0;
    s.pc1 = $urandom; s.pc2 = $urandom; s.upd_pc = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; rdy = s.rdy; insert_en = s.insert_en; mux = s.mux;
    modify_en = s.modify_en; clear = s.clear; choice = s.choice;
    pc1 = s.pc1; pc2 = s.pc2; upd_pc = s.upd_pc;
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    model_step(last_s, last_p1, last_p2);
    drive(s);
    e.p1  = model_pred(s.pc1);
    e.p2  = model_pred(s.pc2);
    e.cyc = cycle;
    exp_q.push_back(e);
    last_s  = s;
    last_p1 = e.p1;
    last_p2 = e.p2;
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("predict1", e.cyc, predict1, e.p1);
        checkOutput("predict2", e.cyc, predict2, e.p2);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    stim_t s;
    s = idle();
    s.rst = 1;
    last_s = s; last_p1 = 0; last_p2 = 0;
    drive(s);

    applyStimulus(s);
    applyStimulus(s);
    repeat (2) applyStimulus(idle());

    // Train taken along the committed history, then let the trained entries show through.
    repeat (3) begin
      s = idle(); s.modify_en = 1; s.choice = 1;
      applyStimulus(s);
    end
    applyStimulus(idle());

    repeat (3) begin
      s = idle(); s.insert_en = 1; s.mux = 0;
      applyStimulus(s);
    end
    s = idle(); s.insert_en = 1; s.mux = 1;
    applyStimulus(s);

    // Recovery collides with an insert in the same cycle.
    s = idle(); s.modify_en = 1; s.clear = 1; s.choice = 0; s.insert_en = 1;
    applyStimulus(s);
    applyStimulus(idle());

    repeat (3) begin
      s = idle(); s.modify_en = 1; s.choice = 0;
      applyStimulus(s);
    end

    // Frozen cycles, and a clear without modify_en.
    repeat (2) begin
      s = idle(); s.rdy = 0; s.modify_en = 1; s.insert_en = 1; s.choice = 1; s.clear = 1;
      applyStimulus(s);
    end
    s = idle(); s.clear = 1; s.insert_en = 1; s.mux = 1;
    applyStimulus(s);

    // Mid-stream reset beats everything else.
    s = idle(); s.rst = 1; s.modify_en = 1; s.insert_en = 1; s.choice = 1;
    applyStimulus(s);
    applyStimulus(idle());

    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst       = ($urandom_range(0, 299) == 0);
      s.rdy       = ($urandom_range(0, 9) != 0);
      s.insert_en = $urandom_range(0, 1);
      s.mux       = $urandom_range(0, 1);
      s.modify_en = $urandom_range(0, 1);
      s.clear     = ($urandom_range(0, 4) == 0);
      s.choice    = ($urandom_range(0, 9) < 6);
      applyStimulus(s);
    end
    applyStimulus(idle());

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
